// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation SAD array.
package me_pkg;

    // SPR shift mode driven by the ME controller.
    typedef enum logic [1:0] {
        SH_DOWN = 2'd0,
        SH_UP   = 2'd1,
        SH_LEFT = 2'd2,
        SH_HOLD = 2'd3
    } shift_e;

    // Exact width of a column SAD: ROWS values of PIX_W bits each.
    function automatic int unsigned sad_width(int unsigned rows, int unsigned pix_w);
        return pix_w + $clog2(rows);
    endfunction

endpackage

// File: rtl/pe_cell.sv
// One row of a SAD column: SPR and CPR pixel registers plus a registered
// absolute difference of the two.
module pe_cell #(
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             spr_en_i,
    input  logic [PIX_W-1:0] spr_d_i,
    input  logic             cpr_en_i,
    input  logic [PIX_W-1:0] cpr_d_i,
    input  logic             ad_en_i,
    output logic [PIX_W-1:0] spr_o,
    output logic [PIX_W-1:0] cpr_o,
    output logic [PIX_W-1:0] ad_o
);

    logic [PIX_W-1:0] spr_q, cpr_q, ad_q, ad_d;
    logic [PIX_W:0]   diff;

    // |spr - cpr| from a zero-extended subtraction; negate when the sign bit is set.
    always_comb begin
        diff = {1'b0, spr_q} - {1'b0, cpr_q};
        ad_d = diff[PIX_W] ? (~diff[PIX_W-1:0] + PIX_W'(1)) : diff[PIX_W-1:0];
    end

    // Pixel and abs-diff registers; flush wins over every enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_q <= '0;
            cpr_q <= '0;
            ad_q  <= '0;
        end else if (flush_i) begin
            spr_q <= '0;
            cpr_q <= '0;
            ad_q  <= '0;
        end else begin
            if (spr_en_i) spr_q <= spr_d_i;
            if (cpr_en_i) cpr_q <= cpr_d_i;
            if (ad_en_i)  ad_q  <= ad_d;
        end
    end

    assign spr_o = spr_q;
    assign cpr_o = cpr_q;
    assign ad_o  = ad_q;

endmodule

// File: rtl/pe_col_sad.sv
// SAD array column: ROWS pe_cells with a four-mode SPR shift network, a CPR
// shift chain, and a registered adder tree producing the column SAD.
module pe_col_sad
    import me_pkg::*;
#(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned SAD_W = sad_width(ROWS, PIX_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  en_spr,
    input  logic                  en_cpr,
    input  logic [1:0]            sel,
    input  logic [PIX_W-1:0]      pixel_spr_in,
    input  logic [PIX_W-1:0]      pixel_cpr_in,
    input  logic [ROWS*PIX_W-1:0] pixel_spr_right_in,
    output logic [PIX_W-1:0]      pixel_cpr_out,
    output logic [ROWS*PIX_W-1:0] pixel_spr_taps,
    input  logic                  valid_in,
    output logic [SAD_W-1:0]      sad_col,
    output logic                  sad_valid
);

    localparam int unsigned LOG = $clog2(ROWS);

    // Bit offset of tree level k (k >= 1) inside the flat sum register.
    function automatic int unsigned lvl_off(int unsigned k);
        int unsigned acc = 0;
        for (int unsigned m = 1; m < k; m++) acc += (ROWS >> m) * (PIX_W + m);
        return acc;
    endfunction

    localparam int unsigned TREE_W = lvl_off(LOG + 1);

    shift_e              sel_e;
    logic                spr_en;
    logic [PIX_W-1:0]    spr_w [ROWS];
    logic [PIX_W-1:0]    cpr_w [ROWS];
    logic [ROWS*PIX_W-1:0] ad_flat;
    logic [TREE_W-1:0]   sum_q;
    logic [LOG:0]        vld_q;

    assign sel_e  = shift_e'(sel);
    // Hold keeps contents, so the cell simply is not written.
    assign spr_en = en_spr && (sel_e != SH_HOLD);

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        logic [PIX_W-1:0] down_src, up_src, cpr_src, spr_next, ad_w;

        if (i == 0) begin : g_top
            assign down_src = pixel_spr_in;
            assign cpr_src  = pixel_cpr_in;
        end else begin : g_mid
            assign down_src = spr_w[i-1];
            assign cpr_src  = cpr_w[i-1];
        end

        if (i == ROWS - 1) begin : g_bot
            assign up_src = pixel_spr_in;
        end else begin : g_nbot
            assign up_src = spr_w[i+1];
        end

        // Per-row SPR source selected by shift mode.
        always_comb begin
            spr_next = spr_w[i];
            unique case (sel_e)
                SH_DOWN: spr_next = down_src;
                SH_UP:   spr_next = up_src;
                SH_LEFT: spr_next = pixel_spr_right_in[i*PIX_W +: PIX_W];
                SH_HOLD: spr_next = spr_w[i];
            endcase
        end

        pe_cell #(
            .PIX_W (PIX_W)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush_i  (flush),
            .spr_en_i (spr_en),
            .spr_d_i  (spr_next),
            .cpr_en_i (en_cpr),
            .cpr_d_i  (cpr_src),
            .ad_en_i  (valid_in),
            .spr_o    (spr_w[i]),
            .cpr_o    (cpr_w[i]),
            .ad_o     (ad_w)
        );

        assign ad_flat[i*PIX_W +: PIX_W]        = ad_w;
        assign pixel_spr_taps[i*PIX_W +: PIX_W] = spr_w[i];
    end

    assign pixel_cpr_out = cpr_w[ROWS-1];

    // Valid pipeline: bit 0 tracks the AD stage, bit k tracks tree level k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LOG-1:0], valid_in};
        end
    end

    for (genvar k = 1; k <= LOG; k++) begin : g_lvl
        localparam int unsigned NI  = ROWS >> (k - 1);
        localparam int unsigned WI  = PIX_W + k - 1;
        localparam int unsigned NO  = ROWS >> k;
        localparam int unsigned WO  = PIX_W + k;
        localparam int unsigned OFF = lvl_off(k);

        logic [NI*WI-1:0] src;

        if (k == 1) begin : g_from_ad
            assign src = ad_flat;
        end else begin : g_from_sum
            assign src = sum_q[lvl_off(k-1) +: NI*WI];
        end

        // Pairwise sums of the previous level, loaded only when that level is valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q[OFF +: NO*WO] <= '0;
            end else if (flush) begin
                sum_q[OFF +: NO*WO] <= '0;
            end else if (vld_q[k-1]) begin
                for (int unsigned j = 0; j < NO; j++) begin
                    sum_q[OFF + j*WO +: WO] <= WO'(src[2*j*WI +: WI])
                                             + WO'(src[(2*j+1)*WI +: WI]);
                end
            end
        end
    end

    assign sad_col   = sum_q[lvl_off(LOG) +: SAD_W];
    assign sad_valid = vld_q[LOG];

endmodule

// File: tb/tb_pe_col_sad.sv
// Bench for pe_col_sad: behavioural column model with a per-cycle compare,
// plus directed literal checks and a small ROWS=4/PIX_W=10 instance.
module tb_pe_col_sad;

    localparam int ROWS  = 16;
    localparam int PIX_W = 8;
    localparam int LAT   = 5;
    localparam int TW    = ROWS * PIX_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, flush, en_spr, en_cpr, valid_in;
    logic [1:0]        sel;
    logic [PIX_W-1:0]  pixel_spr_in, pixel_cpr_in, cpr_out;
    logic [TW-1:0]     right_in, taps;
    logic [11:0]       sad_col;
    logic              sad_valid;

    // Small instance
    logic              s_en_spr, s_en_cpr, s_valid_in, s_flush;
    logic [1:0]        s_sel;
    logic [9:0]        s_spr_in, s_cpr_in, s_cpr_out;
    logic [39:0]       s_right_in, s_taps;
    logic [11:0]       s_sad;
    logic              s_sad_valid;

    pe_col_sad #(.ROWS(ROWS), .PIX_W(PIX_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .en_spr             (en_spr),
        .en_cpr             (en_cpr),
        .sel                (sel),
        .pixel_spr_in       (pixel_spr_in),
        .pixel_cpr_in       (pixel_cpr_in),
        .pixel_spr_right_in (right_in),
        .pixel_cpr_out      (cpr_out),
        .pixel_spr_taps     (taps),
        .valid_in           (valid_in),
        .sad_col            (sad_col),
        .sad_valid          (sad_valid)
    );

    pe_col_sad #(.ROWS(4), .PIX_W(10)) dut4 (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (s_flush),
        .en_spr             (s_en_spr),
        .en_cpr             (s_en_cpr),
        .sel                (s_sel),
        .pixel_spr_in       (s_spr_in),
        .pixel_cpr_in       (s_cpr_in),
        .pixel_spr_right_in (s_right_in),
        .pixel_cpr_out      (s_cpr_out),
        .pixel_spr_taps     (s_taps),
        .valid_in           (s_valid_in),
        .sad_col            (s_sad),
        .sad_valid          (s_sad_valid)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_spr [ROWS];
    int m_cpr [ROWS];
    int q_due [$];
    int q_val [$];
    int last_sad = 0;
    int cyc = 0;
    int acc;

    task automatic model_clear();
        for (int i = 0; i < ROWS; i++) begin
            m_spr[i] = 0;
            m_cpr[i] = 0;
        end
        q_due.delete();
        q_val.delete();
        last_sad = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else if (flush) begin
            model_clear();
            cyc++;
        end else begin
            if (valid_in) begin
                acc = 0;
                for (int i = 0; i < ROWS; i++)
                    acc += (m_spr[i] > m_cpr[i]) ? m_spr[i] - m_cpr[i] : m_cpr[i] - m_spr[i];
                q_due.push_back(cyc + LAT);
                q_val.push_back(acc);
            end
            if (en_spr) begin
                case (sel)
                    2'd0: begin
                        for (int i = ROWS - 1; i > 0; i--) m_spr[i] = m_spr[i-1];
                        m_spr[0] = int'(pixel_spr_in);
                    end
                    2'd1: begin
                        for (int i = 0; i < ROWS - 1; i++) m_spr[i] = m_spr[i+1];
                        m_spr[ROWS-1] = int'(pixel_spr_in);
                    end
                    2'd2: for (int i = 0; i < ROWS; i++) m_spr[i] = int'(right_in[i*PIX_W +: PIX_W]);
                    default: ;
                endcase
            end
            if (en_cpr) begin
                for (int i = ROWS - 1; i > 0; i--) m_cpr[i] = m_cpr[i-1];
                m_cpr[0] = int'(pixel_cpr_in);
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int vcount = 0;
    logic          exp_valid;
    int            exp_col;
    logic [TW-1:0] exp_taps;

    always @(negedge clk) begin
        exp_valid = (q_due.size() > 0) && (q_due[0] == cyc);
        if (exp_valid) begin
            exp_col = q_val.pop_front();
            void'(q_due.pop_front());
            last_sad = exp_col;
        end else begin
            exp_col = last_sad;
        end
        for (int i = 0; i < ROWS; i++) exp_taps[i*PIX_W +: PIX_W] = 8'(m_spr[i]);
        chk("sad_valid", 64'(sad_valid), 64'(exp_valid));
        chk("sad_col", 64'(sad_col), 64'(exp_col));
        chk("cpr_out", 64'(cpr_out), 64'(m_cpr[ROWS-1]));
        tests++;
        if (taps !== exp_taps) begin
            fails++;
            $display("FAIL taps: got %h expected %h at %0t", taps, exp_taps, $time);
        end
        if (sad_valid) vcount++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; en_spr = 0; en_cpr = 0; valid_in = 0; sel = 2'd3;
        pixel_spr_in = '0; pixel_cpr_in = '0; right_in = '0;
    endtask

    task automatic fill(input int spr_v, input int cpr_v);
        en_spr = 1; en_cpr = 1; sel = 2'd0;
        pixel_spr_in = 8'(spr_v); pixel_cpr_in = 8'(cpr_v);
        repeat (ROWS) tick();
        idle();
    endtask

    // Issues one compare and returns cycles from the valid_in cycle to sad_valid.
    task automatic measure(output int lat, output int val);
        valid_in = 1;
        tick();
        valid_in = 0;
        lat = -1;
        val = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (sad_valid) begin
                lat = n + 1;
                val = int'(sad_col);
                break;
            end
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_sad_col"}, 64'(sad_col), 0);
        chk({tag, "_sad_valid"}, 64'(sad_valid), 0);
        chk({tag, "_cpr_out"}, 64'(cpr_out), 0);
        chk({tag, "_taps_or"}, 64'(|taps), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lat, val;

    initial begin
        rst_n = 0;
        idle();
        s_flush = 0; s_en_spr = 0; s_en_cpr = 0; s_valid_in = 0; s_sel = 2'd3;
        s_spr_in = '0; s_cpr_in = '0; s_right_in = '0;
        repeat (3) tick();
        all_zero("reset");
        chk("reset_small_sad", 64'(s_sad), 0);
        rst_n = 1;
        tick();

        // Uniform SAD and maximum value
        fill(200, 50);
        measure(lat, val);
        chk("uniform_latency", 64'(lat), 5);
        chk("uniform_sad", 64'(val), 2400);
        fill(255, 0);
        measure(lat, val);
        chk("max_latency", 64'(lat), 5);
        chk("max_sad", 64'(val), 4080);

        // Down ramp then one up shift
        en_spr = 1; sel = 2'd0;
        for (int k = 0; k < ROWS; k++) begin
            pixel_spr_in = 8'(k);
            tick();
        end
        for (int i = 0; i < ROWS; i++) chk("down_row", 64'(taps[i*PIX_W +: PIX_W]), 64'(15 - i));
        sel = 2'd1; pixel_spr_in = 8'd99;
        tick();
        chk("up_row15", 64'(taps[15*PIX_W +: PIX_W]), 99);
        for (int i = 0; i < ROWS - 1; i++) chk("up_row", 64'(taps[i*PIX_W +: PIX_W]), 64'(14 - i));

        // Left load then hold with en_spr asserted
        sel = 2'd2;
        for (int i = 0; i < ROWS; i++) right_in[i*PIX_W +: PIX_W] = 8'(3 * i);
        tick();
        sel = 2'd3; right_in = '1;
        repeat (4) tick();
        for (int i = 0; i < ROWS; i++) chk("hold_row", 64'(taps[i*PIX_W +: PIX_W]), 64'(3 * i));
        idle();

        // Back-to-back compares while shifting a ramp down
        en_cpr = 1;
        repeat (ROWS) begin
            pixel_cpr_in = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        repeat (LAT + 2) tick();
        vcount = 0;
        en_spr = 1; sel = 2'd0; valid_in = 1;
        for (int k = 0; k < 8; k++) begin
            pixel_spr_in = 8'(k * 17 + 5);
            tick();
        end
        idle();
        repeat (LAT + 2) tick();
        chk("b2b_valid_count", 64'(vcount), 8);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            flush = ($urandom_range(0, 39) == 0);
            en_spr = 1'($urandom);
            en_cpr = 1'($urandom);
            valid_in = 1'($urandom);
            sel = 2'($urandom);
            pixel_spr_in = 8'($urandom);
            pixel_cpr_in = 8'($urandom);
            right_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        idle();

        // Flush mid-pipeline
        fill(180, 20);
        valid_in = 1; tick(); valid_in = 0;
        tick();
        flush = 1; tick(); flush = 0;
        all_zero("flush");
        vcount = 0;
        repeat (LAT + 3) tick();
        chk("flush_no_valid", 64'(vcount), 0);

        // Async reset mid-pipeline
        fill(90, 10);
        valid_in = 1; tick(); valid_in = 0;
        tick();
        #2 rst_n = 0;
        #1 all_zero("async_reset");
        tick();
        rst_n = 1;
        vcount = 0;
        repeat (LAT + 2) tick();
        chk("reset_no_valid", 64'(vcount), 0);

        // CPR cascade
        en_cpr = 1;
        for (int t = 1; t <= 32; t++) begin
            pixel_cpr_in = 8'(t - 1);
            tick();
            chk("cascade", 64'(cpr_out), (t >= 16) ? 64'(t - 16) : 64'd0);
        end
        idle();

        // Small build: latency 3, max 4092
        s_en_spr = 1; s_en_cpr = 1; s_sel = 2'd0; s_spr_in = 10'd1023; s_cpr_in = 10'd0;
        repeat (4) tick();
        s_en_spr = 0; s_en_cpr = 0;
        s_valid_in = 1; tick(); s_valid_in = 0;
        lat = -1; val = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (s_sad_valid) begin
                lat = n + 1;
                val = int'(s_sad);
                break;
            end
        end
        chk("small_latency", 64'(lat), 3);
        chk("small_max_sad", 64'(val), 4092);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
